// File: rtl/led_walk_ctrl_if.sv
// rtl/led_walk_ctrl_if.sv - controller <-> position adder bus
//
// Purpose: carries one add/subtract request from led_walk_ctrl to the
// registered saturating adder and the adder's registered result back.
// Signals:
//   pos_out  [3:0]  current position (adder operand a)
//   da       [1:0]  step magnitude (adder operand da)
//   opn             0 = add, 1 = subtract
//   pos_in   [3:0]  registered adder result (adder fa)
// Modports: master = controller, slave = adder.
interface led_walk_ctrl_if;
   logic [3:0] pos_out;
   logic [1:0] da;
   logic       opn;
   logic [3:0] pos_in;

   modport master (output pos_out, output da, output opn, input pos_in);
   modport slave  (input pos_out, input da, input opn, output pos_in);
endinterface

// File: rtl/led_walk_ctrl.sv
// rtl/led_walk_ctrl.sv - debounced LED walk controller for the position adder
//
// Purpose: debounces up/down buttons, generates auto-walk ticks, issues one
// request to the registered adder, captures its result as the new position
// and drives a one-hot LED pattern.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   btn_up, btn_dn  raw pushbuttons
//   step    [1:0]   step magnitude, sampled when a request is accepted
//   auto_en         enables bounce auto-walk
//   add_if          adder bus (master): pos_out, da, opn out; pos_in in
//   busy            request in flight
//   led     [15:0]  one-hot decode of the position
module led_walk_ctrl #(
   parameter int DB_CYCLES   = 4,
   parameter int AUTO_PERIOD = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_up,
   input  logic              btn_dn,
   input  logic [1:0]        step,
   input  logic              auto_en,
   led_walk_ctrl_if.master   add_if,
   output logic              busy,
   output logic [15:0]       led
);
   localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int PW  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
   localparam logic [PW-1:0]  PER_LAST = PW'(AUTO_PERIOD - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_CAPTURE = 2'd2;

   // index 0 = up button, index 1 = down button
   logic [1:0]     sync1_q, sync2_q, db_q, db_d, rise;
   logic [DBW-1:0] cnt_q [2];
   logic [DBW-1:0] cnt_d [2];

   logic [1:0]    state_q, state_d;
   logic [3:0]    pos_q, pos_d;
   logic [1:0]    da_q, da_d;
   logic          opn_q, opn_d;
   logic          busy_q, busy_d;
   logic          dir_q, dir_d;      // 0 = walking up, 1 = walking down
   logic [PW-1:0] per_q, per_d;
   logic          auto_run, tick, req, req_dir;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         db_d[i]  = db_q[i];
         cnt_d[i] = '0;
         rise[i]  = 1'b0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               db_d[i] = sync2_q[i];
               // request pulse fires on the same cycle the debounced level rises
               rise[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DBW'(1);
            end
         end
      end
   end

   always_comb begin
      auto_run = auto_en && (state_q == S_IDLE);
      tick     = auto_run && (per_q == PER_LAST);
      if (!auto_en)      per_d = '0;
      else if (tick)     per_d = '0;
      else if (auto_run) per_d = per_q + PW'(1);
      else               per_d = per_q;

      // simultaneous up/down pulses cancel each other and also swallow a tick
      req     = 1'b0;
      req_dir = 1'b0;
      if (rise[0] ^ rise[1]) begin
         req     = 1'b1;
         req_dir = rise[1];
      end else if (!rise[0] && !rise[1] && tick) begin
         req     = 1'b1;
         req_dir = dir_q;
      end

      state_d = state_q;
      pos_d   = pos_q;
      da_d    = da_q;
      opn_d   = opn_q;
      busy_d  = busy_q;
      dir_d   = dir_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               da_d    = step;
               opn_d   = req_dir;
               busy_d  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            pos_d   = add_if.pos_in;
            da_d    = 2'd0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
            if (add_if.pos_in == 4'd15)     dir_d = 1'b1;
            else if (add_if.pos_in == 4'd0) dir_d = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_q     <= '0;
         cnt_q[0] <= '0;
         cnt_q[1] <= '0;
         state_q  <= S_IDLE;
         pos_q    <= '0;
         da_q     <= '0;
         opn_q    <= 1'b0;
         busy_q   <= 1'b0;
         dir_q    <= 1'b0;
         per_q    <= '0;
      end else begin
         sync1_q  <= {btn_dn, btn_up};
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
         state_q  <= state_d;
         pos_q    <= pos_d;
         da_q     <= da_d;
         opn_q    <= opn_d;
         busy_q   <= busy_d;
         dir_q    <= dir_d;
         per_q    <= per_d;
      end
   end

   assign add_if.pos_out = pos_q;
   assign add_if.da      = da_q;
   assign add_if.opn     = opn_q;
   assign busy           = busy_q;
   assign led            = 16'h0001 << pos_q;
endmodule

// File: tb/tb_led_walk_ctrl.sv
// tb/tb_led_walk_ctrl.sv - scoreboard bench for led_walk_ctrl
module tb_led_walk_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        btn_up = 1'b0, btn_dn = 1'b0, auto_en = 1'b0;
   logic [1:0]  step = 2'd0;
   logic        busy;
   logic [15:0] led;

   led_walk_ctrl_if bus ();

   led_walk_ctrl #(.DB_CYCLES(4), .AUTO_PERIOD(16)) dut (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .step(step),
      .auto_en(auto_en), .add_if(bus), .busy(busy), .led(led)
   );

   always #5 clk = ~clk;

   function automatic logic [3:0] sat(input logic [3:0] p, input logic [1:0] s, input logic sub);
      int r;
      r = sub ? int'(p) - int'(s) : int'(p) + int'(s);
      if (r < 0) r = 0;
      if (r > 15) r = 15;
      return 4'(r);
   endfunction

   // registered saturating adder on the far side of the bus
   always_ff @(posedge clk or posedge rst) begin
      if (rst) bus.pos_in <= 4'd0;
      else     bus.pos_in <= sat(bus.pos_out, bus.da, bus.opn);
   end

   int total = 0, bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [3:0] pos;
      logic [1:0] da;
      logic       opn;
   } exp_t;

   exp_t       sb[$];
   logic [3:0] m_pos = 4'd0;
   logic       m_dir = 1'b0;
   int         n_caps = 0, cyc = 0, last_cap = 0, busy_len = 0;
   logic       busy_prev = 1'b0;

   function automatic void push(input logic [1:0] s, input logic sub);
      exp_t e;
      m_pos = sat(m_pos, s, sub);
      if (m_pos == 4'd15)     m_dir = 1'b1;
      else if (m_pos == 4'd0) m_dir = 1'b0;
      e.pos = m_pos; e.da = s; e.opn = sub;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         busy_prev = 1'b0;
         busy_len  = 0;
      end else begin
         if (busy && !busy_prev) begin
            if (sb.size() == 0) check("spurious_req", 1, 0);
            else begin
               check("issue_da", bus.da, sb[0].da);
               check("issue_opn", bus.opn, sb[0].opn);
            end
         end
         if (busy) busy_len++;
         if (!busy && busy_prev) begin
            check("busy_len", busy_len, 2);
            busy_len = 0;
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("cap_pos", bus.pos_out, e.pos);
               check("cap_led", led, 16'h0001 << e.pos);
            end
            n_caps++;
            last_cap = cyc;
         end
         busy_prev = busy;
      end
   end

   task automatic press(input logic up, input logic [1:0] s);
      step = s;
      push(s, !up);
      if (up) btn_up = 1'b1; else btn_dn = 1'b1;
      repeat (10) @(negedge clk);
      btn_up = 1'b0; btn_dn = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic wait_caps(input int target);
      int n = 0;
      while (n_caps < target && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n_caps < target) check("timeout_cap", n_caps, target);
   endtask

   initial begin
      int prev;
      // reset with buttons toggling
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         btn_up = ~btn_up;
         btn_dn = i[1];
      end
      check("rst_pos", bus.pos_out, 0);
      check("rst_led", led, 16'h0001);
      check("rst_busy", busy, 0);
      check("rst_da", bus.da, 0);
      btn_up = 1'b0; btn_dn = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);

      // single held up press
      press(1'b1, 2'd2);
      check("up_pos", bus.pos_out, 2);
      check("up_led", led, 16'h0004);

      // bouncing down button, then held
      step = 2'd1;
      for (int i = 0; i < 10; i++) begin
         btn_dn = ~btn_dn;
         repeat (2) @(negedge clk);
      end
      check("bounce_no_req", n_caps, 1);
      press(1'b0, 2'd1);
      check("bounce_pos", bus.pos_out, 1);

      // saturation both ways
      for (int i = 0; i < 4; i++) press(1'b1, 2'd3);
      press(1'b1, 2'd1);
      press(1'b1, 2'd3);
      check("sat_hi", bus.pos_out, 15);
      for (int i = 0; i < 4; i++) press(1'b0, 2'd3);
      press(1'b0, 2'd2);
      check("pre_sat_lo", bus.pos_out, 1);
      press(1'b0, 2'd3);
      check("sat_lo", bus.pos_out, 0);

      // down button coincident with an up tick: button (opn=1) must win
      step = 2'd2;
      push(2'd2, 1'b1);
      auto_en = 1'b1;
      repeat (10) @(negedge clk);
      btn_dn = 1'b1;
      repeat (10) @(negedge clk);
      auto_en = 1'b0;
      btn_dn = 1'b0;
      repeat (12) @(negedge clk);
      check("tick_vs_btn_caps", n_caps, 15);

      // second pulse while busy is dropped
      step = 2'd1;
      push(2'd1, 1'b0);
      btn_up = 1'b1;
      @(negedge clk);
      btn_dn = 1'b1;
      repeat (10) @(negedge clk);
      btn_up = 1'b0; btn_dn = 1'b0;
      repeat (12) @(negedge clk);
      check("busy_drop_pos", bus.pos_out, 1);

      // simultaneous up/down: no request
      prev = n_caps;
      btn_up = 1'b1; btn_dn = 1'b1;
      repeat (10) @(negedge clk);
      btn_up = 1'b0; btn_dn = 1'b0;
      repeat (12) @(negedge clk);
      check("simul_none", n_caps, prev);

      // auto walk from 0 with step 3
      press(1'b0, 2'd1);
      check("auto_start", bus.pos_out, 0);
      step = 2'd3;
      for (int i = 0; i < 8; i++) push(2'd3, m_dir);
      prev = n_caps;
      auto_en = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         int t0;
         t0 = last_cap;
         wait_caps(prev + i);
         if (i > 1) check("auto_gap", last_cap - t0, 18);
      end
      check("auto_pos7", bus.pos_out, 9);

      // async reset while the 8th request is in CAPTURE
      begin
         int n = 0;
         while (!busy && n < 40) begin
            @(negedge clk);
            n++;
         end
         check("auto_8th_seen", busy, 1);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_pos", bus.pos_out, 0);
      check("midrst_busy", busy, 0);
      check("midrst_led", led, 16'h0001);
      check("midrst_da", bus.da, 0);
      auto_en = 1'b0;
      repeat (2) @(negedge clk);
      sb.delete();
      m_pos = 4'd0; m_dir = 1'b0;
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("post_rst_pos", bus.pos_out, 0);
      check("sb_empty", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/led_walk_ctrl.md
Name: led_walk_ctrl

Overview:
- Controller that sits on the other side of the registered saturating 4-bit position adder in led_walk_top.
- Debounces up/down pushbuttons and generates an auto-walk tick, then issues one add/subtract request (a, da, opn) to the adder.
- Waits for the adder's registered result, captures it as the new LED position, and drives a one-hot 16-LED pattern.
- Owns the position register; the adder stays a pure one-cycle registered datapath.

Parameters:
- DB_CYCLES, 4: consecutive cycles a raw button must hold one level before its debounced value changes. Top-level overrides this for hardware, e.g. 500000.
- AUTO_PERIOD, 16: cycles between auto-walk ticks while auto_en=1. Minimum 4.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- btn_up  in  1  raw pushbutton, step position up.
- btn_dn  in  1  raw pushbutton, step position down.
- step  in  2  step magnitude 0..3, sampled at request acceptance.
- auto_en  in  1  enables the auto-walk (bounce) mode.
- pos_in  in  4  registered sum from the adder (its fa output).
- pos_out  out  4  current position, drives the adder's a input.
- da  out  2  step magnitude presented to the adder.
- opn  out  1  0 = add, 1 = subtract, presented to the adder.
- busy  out  1  high while a request is in flight.
- led  out  16  one-hot: led[pos_out] = 1.

Behaviour:
- Reset (async, rst=1): pos_out=0, da=0, opn=0, busy=0, led=16'h0001, state=IDLE, dir=up, debounce and period counters=0, debounced buttons=0.
- Debounce, per button:
  - The raw input is synchronised through 2 flops.
  - A counter increments while the synced value differs from the debounced value, and clears when they match.
  - When the counter reaches DB_CYCLES-1, the debounced value flips and the counter clears.
  - A request pulse is generated on a debounced rising edge only.
- Auto tick:
  - The period counter runs only while auto_en=1 and state=IDLE.
  - It produces a 1-cycle tick at AUTO_PERIOD-1, then wraps to 0.
  - auto_en=0 clears the counter.
- Request arbitration, in IDLE only:
  - up pulse alone: opn=0.
  - dn pulse alone: opn=1.
  - up and dn pulses in the same cycle: both dropped, no request.
  - Any button pulse beats an auto tick in the same cycle; the tick is dropped.
  - Auto tick alone: opn = (dir==down).
  - Pulses or ticks arriving while busy=1 are dropped, not queued.
- FSM, states IDLE, ISSUE, CAPTURE:
  - IDLE: da=0, opn holds its last value (da=0 makes the adder return pos unchanged). On an accepted request, at the posedge: da<=step, opn<=direction, busy<=1, go to ISSUE.
  - ISSUE: da/opn held stable for one cycle. The adder registers its result at this posedge. Go to CAPTURE.
  - CAPTURE: at the posedge, pos_out<=pos_in, da<=0, busy<=0, go to IDLE.
  - Latency: request accepted at edge N; pos_out and led update at edge N+2.
  - Throughput: at most 1 step every 3 cycles.
- Saturation is performed by the adder, not re-checked here:
  - Up from 14 with step=3 gives 15.
  - Down from 1 with step=2 gives 0.
- step=0 request: the full 3-cycle sequence runs and pos is unchanged.
- Bounce direction, evaluated in CAPTURE using the captured value:
  - If pos_in==15, dir<=down.
  - If pos_in==0, dir<=up.
  - Button-driven steps also update dir by this rule.
- auto_en falling mid-request: the in-flight request completes. Ticks stop from the next IDLE cycle.
- rst asserted mid-request: immediate return to reset values; the in-flight result is discarded.
- led: combinational decode of pos_out, always exactly one bit high.

Test Plan:
- Reset: hold rst with buttons toggling -> pos_out=0, led=16'h0001, busy=0, da=0. Release rst -> no spurious step.
- Up step: step=2, btn_up held stable 1 for 10 cycles.
  - Exactly one request; busy high 2 cycles; da=2, opn=0 during ISSUE.
  - pos_out=2, led=16'h0004.
  - Holding the button causes no further steps.
- Bounce/debounce: btn_dn toggling every 2 cycles (shorter than DB_CYCLES) for 20 cycles, then held -> no request during toggling, exactly one request after stable.
- Saturation:
  - From pos=14, up with step=3 -> pos_out=15, dir=down.
  - From pos=1, down with step=3 -> pos_out=0, dir=up.
- Simultaneous events:
  - btn_up and btn_dn debounced on the same cycle -> no request.
  - Button pulse coincident with an auto tick -> button wins, only one step.
  - Pulse while busy=1 -> dropped, pos changes by one step only.
- Auto walk: auto_en=1, step=3, from pos=0 -> positions 3,6,9,12,15,12,9,... with one step per AUTO_PERIOD+2 cycles. Async rst in CAPTURE -> pos_out=0 immediately.
